// File: rtl/reg_bank_pkg.sv
// Shared constants and reset-value table for the configuration register bank.
// Reset values are returned wide so that any bank width can truncate them.
package reg_bank_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        ACC_OK    = 2'd0,
        ACC_RANGE = 2'd1,
        ACC_RO    = 2'd2
    } acc_status_e;

    function automatic logic [63:0] rst_val(input int idx);
        case (idx)
            2:       return 64'h81;
            3:       return 64'h20;
            default: return 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/reg_bank_cfg_if.sv
// Request/response bus between a host and the configuration register bank.
interface reg_bank_cfg_if #(
    parameter int WIDTH = reg_bank_pkg::DEF_WIDTH,
    parameter int ADDR  = $clog2(reg_bank_pkg::DEF_DEPTH)
);

    logic             WrEn;
    logic             RdEn;
    logic [ADDR-1:0]  Address;
    logic [WIDTH-1:0] WrData;
    logic             RdReady;
    logic [WIDTH-1:0] RdData;
    logic             RdData_Valid;
    logic             Rd_Stall;
    logic             Addr_Err;

    modport master (
        output WrEn, RdEn, Address, WrData, RdReady,
        input  RdData, RdData_Valid, Rd_Stall, Addr_Err
    );

    modport slave (
        input  WrEn, RdEn, Address, WrData, RdReady,
        output RdData, RdData_Valid, Rd_Stall, Addr_Err
    );

endinterface

// File: rtl/reg_rd_slot.sv
// Single-entry read response holder with valid/ready handshake.
// A request arriving while the slot is full and not being drained is dropped.
module reg_rd_slot #(
    parameter int WIDTH = reg_bank_pkg::DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             rd_req,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             RdReady,
    output logic [WIDTH-1:0] RdData,
    output logic             RdData_Valid,
    output logic             Rd_Stall,
    output logic             rd_accept
);

    assign rd_accept = rd_req && (!RdData_Valid || RdReady);
    assign Rd_Stall  = rd_req && RdData_Valid && !RdReady;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RdData       <= '0;
            RdData_Valid <= 1'b0;
        end else if (rd_accept) begin
            RdData       <= rd_data;
            RdData_Valid <= 1'b1;
        end else if (RdReady) begin
            RdData_Valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_bank_cfg.sv
// Configuration register bank: per-register read-only mask, exported live
// contents of the low registers, change pulses and an illegal-access flag.
module reg_bank_cfg
    import reg_bank_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter int               ADDR    = $clog2(DEPTH),
    parameter int               NUM_EXP = 4,
    parameter logic [DEPTH-1:0] RO_MASK = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    reg_bank_cfg_if.slave            bus,
    output logic [NUM_EXP*WIDTH-1:0] REG_EXP,
    output logic [NUM_EXP-1:0]       Reg_Upd
);

    logic [WIDTH-1:0]   regs [DEPTH];
    logic [ADDR-1:0]    addr;
    logic               in_range;
    acc_status_e        wr_status;
    logic               wr_ok;
    logic               wr_err;
    logic               rd_accept;
    logic [WIDTH-1:0]   rd_src;
    logic [NUM_EXP-1:0] upd_next;
    logic               addr_err_q;

    assign addr     = bus.Address;
    assign in_range = int'(addr) < DEPTH;

    always_comb begin
        wr_status = ACC_OK;
        if (!in_range) begin
            wr_status = ACC_RANGE;
        end else if (RO_MASK[addr]) begin
            wr_status = ACC_RO;
        end
    end

    assign wr_ok  = bus.WrEn && (wr_status == ACC_OK);
    assign wr_err = bus.WrEn && (wr_status != ACC_OK);

    // Reads sample the pre-edge contents, so a same-cycle write is not visible.
    assign rd_src = in_range ? regs[addr] : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= WIDTH'(rst_val(i));
            end
        end else if (wr_ok) begin
            regs[addr] <= bus.WrData;
        end
    end

    always_comb begin
        upd_next = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (wr_ok && (int'(addr) == i) && (bus.WrData != regs[i])) begin
                upd_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Reg_Upd    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            Reg_Upd    <= upd_next;
            addr_err_q <= wr_err || (rd_accept && !in_range);
        end
    end

    assign bus.Addr_Err = addr_err_q;

    for (genvar g = 0; g < NUM_EXP; g++) begin : g_exp
        assign REG_EXP[g*WIDTH +: WIDTH] = regs[g];
    end

    reg_rd_slot #(
        .WIDTH (WIDTH)
    ) u_rd_slot (
        .CLK          (CLK),
        .RST          (RST),
        .rd_req       (bus.RdEn),
        .rd_data      (rd_src),
        .RdReady      (bus.RdReady),
        .RdData       (bus.RdData),
        .RdData_Valid (bus.RdData_Valid),
        .Rd_Stall     (bus.Rd_Stall),
        .rd_accept    (rd_accept)
    );

endmodule

// File: tb/tb_reg_bank_cfg.sv
// Bench for reg_bank_cfg: directed vector table, mid-cycle reset sequence and
// randomized traffic against a behavioural register-bank model.
module tb_reg_bank_cfg;

    localparam int          WIDTH   = 8;
    localparam int          DEPTH   = 12;
    localparam int          NUM_EXP = 4;
    localparam logic [11:0] RO      = 12'h020;

    logic        CLK;
    logic        RST;
    logic [31:0] reg_exp;
    logic [3:0]  reg_upd;

    reg_bank_cfg_if #(.WIDTH(WIDTH), .ADDR(4)) bus ();

    reg_bank_cfg #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .NUM_EXP (NUM_EXP),
        .RO_MASK (RO)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus),
        .REG_EXP (reg_exp),
        .Reg_Upd (reg_upd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [DEPTH];
    logic [7:0] m_rd;
    bit         m_valid;
    bit         m_err;
    logic [3:0] m_upd;
    bit         sampled_stall;

    typedef struct {
        bit         wr;
        bit         rd;
        int         addr;
        logic [7:0] data;
        bit         rdy;
        bit         exp_stall;
        bit         exp_valid;
        logic [7:0] exp_rd;
        bit         exp_err;
        logic [3:0] exp_upd;
    } vec_t;

    vec_t vecs [17];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        mem[2]  = 8'h81;
        mem[3]  = 8'h20;
        m_rd    = 8'h00;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_upd   = 4'h0;
    endfunction

    function automatic logic [31:0] modelExp();
        return {mem[3], mem[2], mem[1], mem[0]};
    endfunction

    // One bus cycle: drive, check the combinational stall, advance the model, check after the edge.
    task automatic applyStimulus(input bit wr, input bit rd, input int addr,
                                 input logic [7:0] data, input bit rdy);
        bit         in_range;
        bit         writable;
        bit         accept;
        logic [7:0] rd_val;
        bus.WrEn    = wr;
        bus.RdEn    = rd;
        bus.Address = 4'(addr);
        bus.WrData  = data;
        bus.RdReady = rdy;
        #1;
        sampled_stall = bus.Rd_Stall;
        checkOutput("rd_stall", 64'(bus.Rd_Stall), 64'(rd && m_valid && !rdy));

        in_range = addr < DEPTH;
        writable = in_range ? !RO[addr] : 1'b0;
        accept   = rd && (!m_valid || rdy);
        rd_val   = in_range ? mem[addr] : 8'h00;
        m_err    = (wr && !writable) || (accept && !in_range);
        m_upd    = 4'h0;
        if (wr && writable && addr < NUM_EXP && mem[addr] != data) m_upd[addr] = 1'b1;
        if (wr && writable) mem[addr] = data;
        if (accept) begin
            m_rd    = rd_val;
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end

        @(posedge CLK);
        #1;
        checkOutput("rd_valid", 64'(bus.RdData_Valid), 64'(m_valid));
        if (m_valid) checkOutput("rd_data", 64'(bus.RdData), 64'(m_rd));
        checkOutput("addr_err", 64'(bus.Addr_Err), 64'(m_err));
        checkOutput("reg_upd", 64'(reg_upd), 64'(m_upd));
        checkOutput("reg_exp", 64'(reg_exp), 64'(modelExp()));
    endtask

    initial begin
        int         a;
        logic [7:0] d;

        vecs[0]  = '{0, 1, 0,  8'h00, 1, 0, 1, 8'h00, 0, 4'h0};
        vecs[1]  = '{0, 1, 1,  8'h00, 1, 0, 1, 8'h00, 0, 4'h0};
        vecs[2]  = '{0, 1, 2,  8'h00, 1, 0, 1, 8'h81, 0, 4'h0};
        vecs[3]  = '{0, 1, 3,  8'h00, 1, 0, 1, 8'h20, 0, 4'h0};
        vecs[4]  = '{0, 0, 0,  8'h00, 1, 0, 0, 8'h20, 0, 4'h0};
        vecs[5]  = '{1, 0, 1,  8'h5A, 1, 0, 0, 8'h20, 0, 4'h2};
        vecs[6]  = '{1, 0, 1,  8'h5A, 1, 0, 0, 8'h20, 0, 4'h0};
        vecs[7]  = '{0, 1, 2,  8'h00, 0, 0, 1, 8'h81, 0, 4'h0};
        vecs[8]  = '{0, 1, 3,  8'h00, 0, 1, 1, 8'h81, 0, 4'h0};
        vecs[9]  = '{0, 0, 0,  8'h00, 1, 0, 0, 8'h81, 0, 4'h0};
        vecs[10] = '{1, 1, 4,  8'hC3, 1, 0, 1, 8'h00, 0, 4'h0};
        vecs[11] = '{0, 1, 4,  8'h00, 1, 0, 1, 8'hC3, 0, 4'h0};
        vecs[12] = '{0, 0, 0,  8'h00, 1, 0, 0, 8'hC3, 0, 4'h0};
        vecs[13] = '{1, 0, 5,  8'h77, 1, 0, 0, 8'hC3, 1, 4'h0};
        vecs[14] = '{0, 1, 14, 8'h00, 1, 0, 1, 8'h00, 1, 4'h0};
        vecs[15] = '{0, 1, 5,  8'h00, 1, 0, 1, 8'h00, 0, 4'h0};
        vecs[16] = '{1, 0, 14, 8'h11, 1, 0, 0, 8'h00, 1, 4'h0};

        RST         = 1'b1;
        bus.WrEn    = 1'b0;
        bus.RdEn    = 1'b0;
        bus.Address = '0;
        bus.WrData  = '0;
        bus.RdReady = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_valid", 64'(bus.RdData_Valid), 64'h0);
        checkOutput("reset_rd_data", 64'(bus.RdData), 64'h0);
        checkOutput("reset_addr_err", 64'(bus.Addr_Err), 64'h0);
        checkOutput("reset_reg_upd", 64'(reg_upd), 64'h0);
        checkOutput("reset_reg_exp", 64'(reg_exp), 64'h2081_0000);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_stall", i), 64'(sampled_stall), 64'(vecs[i].exp_stall));
            checkOutput($sformatf("vec%0d_valid", i), 64'(bus.RdData_Valid), 64'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_rd_data", i), 64'(bus.RdData), 64'(vecs[i].exp_rd));
            checkOutput($sformatf("vec%0d_addr_err", i), 64'(bus.Addr_Err), 64'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_reg_upd", i), 64'(reg_upd), 64'(vecs[i].exp_upd));
        end
        checkOutput("reg1_after_5a", 64'(reg_exp[15:8]), 64'h5A);

        // Reset asserted mid-cycle while a response is pending.
        applyStimulus(1, 0, 0, 8'h3C, 1);
        applyStimulus(0, 1, 2, 8'h00, 0);
        checkOutput("pre_reset_valid", 64'(bus.RdData_Valid), 64'h1);
        bus.RdEn = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        checkOutput("async_valid", 64'(bus.RdData_Valid), 64'h0);
        checkOutput("async_rd_data", 64'(bus.RdData), 64'h0);
        checkOutput("async_addr_err", 64'(bus.Addr_Err), 64'h0);
        checkOutput("async_reg_upd", 64'(reg_upd), 64'h0);
        checkOutput("async_reg_exp", 64'(reg_exp), 64'h2081_0000);
        modelReset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        applyStimulus(0, 1, 3, 8'h00, 1);
        checkOutput("first_read_after_reset", 64'(bus.RdData), 64'h20);

        for (int n = 0; n < 400; n++) begin
            a = int'($urandom_range(0, 15));
            if (a < DEPTH && $urandom_range(0, 3) == 0) d = mem[a];
            else d = 8'($urandom);
            applyStimulus($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 5, a, d,
                          $urandom_range(0, 9) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
